npu_issue_ctrl: RTL

NPU_ISSUE_CTRL -- requirements
Module: npu_issue_ctrl

---
 rtl/npu_issue_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/npu_issue_ctrl.sv
// Issue controller for the NPU custom op: latches operands, handshakes the request,
// waits for the response (with timeout) and produces a single register-file writeback.
`timescale 1ns/1ps
module npu_issue_ctrl #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dec_valid,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            npu_req_valid,
    input  logic            npu_req_ready,
    output logic [XLEN-1:0] npu_op_a,
    output logic [XLEN-1:0] npu_op_b,
    input  logic            npu_resp_valid,
    input  logic [XLEN-1:0] npu_resp_data,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            npu_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t          state, state_nx;
    logic [15:0]     wait_cnt;
    logic [XLEN-1:0] op_a_q, op_b_q, wb_data_q;
    logic [4:0]      rd_q;
    logic            timeout_q;
    logic            launch;

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        launch   = 1'b0;
        case (state)
            IDLE: begin
                if (dec_valid && alu_op == 4'b1111 && !flush) begin
                    launch   = 1'b1;
                    stall    = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                stall = 1'b1;
                // An accepted handshake takes priority over a same-cycle flush
                if (npu_req_ready)
                    state_nx = WAIT;
                else if (flush)
                    state_nx = IDLE;
            end
            WAIT: begin
                stall = 1'b1;
                if (npu_resp_valid || wait_cnt == CNT_LAST)
                    state_nx = WB;
            end
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (launch) begin
                op_a_q <= rs1_val;
                op_b_q <= rs2_val;
                rd_q   <= rd_addr;
            end
            if (state == ISSUE && npu_req_ready)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + 16'd1;
            // A response on the final wait cycle beats the timeout
            if (state == WAIT) begin
                if (npu_resp_valid) begin
                    wb_data_q <= npu_resp_data;
                end else if (wait_cnt == CNT_LAST) begin
                    wb_data_q <= '0;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign busy          = (state != IDLE);
    assign npu_req_valid = (state == ISSUE);
    assign npu_op_a      = op_a_q;
    assign npu_op_b      = op_b_q;
    assign wb_valid      = (state == WB) && (rd_q != 5'd0);
    assign wb_rd         = rd_q;
    assign wb_data       = wb_data_q;
    assign npu_timeout   = timeout_q;

endmodule
